// File: rtl/debug_dump_pkg.sv
// Shared constants and state encoding for the debug register dumper.
// DEBUG_DUMP_CHECKSUM_EN selects the 70-byte checksummed frame.
package debug_dump_pkg;

    localparam logic [7:0] DUMP_HEADER     = 8'hA5;
    localparam int         DUMP_NUM_REGS   = 16;
    localparam int         DUMP_BYTES      = 69;
    localparam int         DUMP_BYTES_CSUM = 70;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        SELECT,
        CAPTURE,
        FINISH
    } dump_state_t;

    function automatic logic [7:0] word_byte(
        input logic [31:0] w,
        input logic [1:0]  idx
    );
        return w[8*idx +: 8];
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte transmitter; byte_done flags the last cycle of the stop bit
// so a back-to-back load starts the next start bit with no gap.
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready,
    output logic       byte_done
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    logic [CW-1:0] cnt;
    logic [3:0]    bit_idx;
    logic [8:0]    shreg;
    logic          active;
    logic          last_clk;

    assign last_clk  = cnt == CW'(CLKS_PER_BIT - 1);
    assign ready     = !active;
    assign byte_done = active && last_clk && bit_idx == 4'd9;

    // bit_idx: 0 start, 1..8 data, 9 stop
    always_ff @(posedge clk) begin
        if (reset) begin
            active  <= 1'b0;
            tx      <= 1'b1;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else if (load) begin
            active  <= 1'b1;
            tx      <= 1'b0;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= {1'b1, data};
        end else if (active) begin
            if (last_clk) begin
                cnt <= '0;
                if (bit_idx == 4'd9) begin
                    active <= 1'b0;
                    tx     <= 1'b1;
                end else begin
                    tx      <= shreg[0];
                    shreg   <= {1'b1, shreg[8:1]};
                    bit_idx <= bit_idx + 4'd1;
                end
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/debug_reg_dumper.sv
// Dumps PC and R0..R15 as one framed UART stream on a start pulse.
// DEBUG_DUMP_CHECKSUM_EN appends an XOR byte over the PC/register bytes.
module debug_reg_dumper
    import debug_dump_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] fetchPC,
    input  logic [31:0] debug_reg_out,
    output logic [3:0]  debug_reg_select,
    output logic        uart_tx,
    output logic        busy,
    output logic        done
);

    localparam logic [3:0] LAST_REG = 4'(DUMP_NUM_REGS - 1);

    dump_state_t state;
    logic [31:0] word_buf;
    logic [1:0]  byte_idx;
    logic [3:0]  reg_idx;
    logic        last_reg;
    logic        hdr;
    logic        accept;
    logic        more;
    logic        tx_load;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        tx_byte_done;
`ifdef DEBUG_DUMP_CHECKSUM_EN
    logic [7:0]  csum;
    logic        csum_phase;
    logic        payload;
`endif

    assign accept = start && tx_ready;

`ifdef DEBUG_DUMP_CHECKSUM_EN
    assign more = hdr || byte_idx != 2'd3 ||
                  (last_reg && !csum_phase);
`else
    assign more = hdr || byte_idx != 2'd3;
`endif

    always_comb begin
        tx_load = 1'b0;
        tx_data = DUMP_HEADER;
        unique case (state)
            IDLE: tx_load = accept;
            CAPTURE: begin
                tx_load = 1'b1;
                tx_data = debug_reg_out[7:0];
            end
            SEND: begin
                tx_load = tx_byte_done && more;
                if (hdr)
                    tx_data = word_buf[7:0];
                else if (byte_idx != 2'd3)
                    tx_data = word_byte(word_buf,
                                        byte_idx + 2'd1);
`ifdef DEBUG_DUMP_CHECKSUM_EN
                else
                    tx_data = csum;
`endif
            end
            default: ;
        endcase
    end

`ifdef DEBUG_DUMP_CHECKSUM_EN
    // header and the checksum byte itself stay out of the XOR
    assign payload = tx_load &&
        (state == CAPTURE ||
         (state == SEND && (hdr || byte_idx != 2'd3)));
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            busy             <= 1'b0;
            done             <= 1'b0;
            debug_reg_select <= '0;
            word_buf         <= '0;
            byte_idx         <= '0;
            reg_idx          <= '0;
            last_reg         <= 1'b0;
            hdr              <= 1'b0;
`ifdef DEBUG_DUMP_CHECKSUM_EN
            csum             <= '0;
            csum_phase       <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef DEBUG_DUMP_CHECKSUM_EN
            if (payload)
                csum <= csum ^ tx_data;
`endif
            unique case (state)
                IDLE: if (accept) begin
                    word_buf <= fetchPC;
                    hdr      <= 1'b1;
                    byte_idx <= '0;
                    reg_idx  <= '0;
                    last_reg <= 1'b0;
                    busy     <= 1'b1;
                    state    <= SEND;
`ifdef DEBUG_DUMP_CHECKSUM_EN
                    csum       <= '0;
                    csum_phase <= 1'b0;
`endif
                end
                SEND: if (tx_byte_done) begin
                    if (hdr)
                        hdr <= 1'b0;
                    else if (byte_idx != 2'd3)
                        byte_idx <= byte_idx + 2'd1;
`ifdef DEBUG_DUMP_CHECKSUM_EN
                    else if (last_reg && !csum_phase)
                        csum_phase <= 1'b1;
`endif
                    else if (last_reg) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FINISH;
                    end else begin
                        byte_idx <= '0;
                        state    <= SELECT;
                    end
                end
                SELECT: begin
                    debug_reg_select <= reg_idx;
                    last_reg <= reg_idx == LAST_REG;
                    reg_idx  <= reg_idx + 4'd1;
                    state    <= CAPTURE;
                end
                CAPTURE: begin
                    word_buf <= debug_reg_out;
                    state    <= SEND;
                end
                FINISH: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk      (clk),
        .reset    (reset),
        .load     (tx_load),
        .data     (tx_data),
        .tx       (uart_tx),
        .ready    (tx_ready),
        .byte_done(tx_byte_done)
    );

endmodule

// File: tb/tb_debug_reg_dumper.sv
// Scoreboard bench for debug_reg_dumper: UART decoder vs frame model.
// Honours DEBUG_DUMP_CHECKSUM_EN for frame length and checksum byte.
module tb_debug_reg_dumper;

    localparam int CPB = 4;
`ifdef DEBUG_DUMP_CHECKSUM_EN
    localparam int NBYTES = 70;
`else
    localparam int NBYTES = 69;
`endif
    localparam int FRAME_CYC = NBYTES * 10 * CPB + 32;

    typedef struct {
        logic [7:0] b;
        logic [3:0] sel;
        bit         chk_sel;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] fetchPC = '0;
    logic [31:0] regs [16];
    logic [31:0] debug_reg_out;
    logic [3:0]  debug_reg_select;
    logic        uart_tx;
    logic        busy;
    logic        done;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   rx_count = 0;
    int   t0 = 0;
    exp_t sb[$];

    assign debug_reg_out = regs[debug_reg_select];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (done)
            done_cnt <= done_cnt + 1;
    end

    debug_reg_dumper #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .fetchPC         (fetchPC),
        .debug_reg_out   (debug_reg_out),
        .debug_reg_select(debug_reg_select),
        .uart_tx         (uart_tx),
        .busy            (busy),
        .done            (done)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h",
                     tag, got, exp);
        end
    endtask

    task automatic push_frame(input logic [31:0] pc);
        exp_t e;
        logic [31:0] w;
`ifdef DEBUG_DUMP_CHECKSUM_EN
        logic [7:0] cs;
        cs = '0;
`endif
        e.b = 8'hA5;
        e.sel = '0;
        e.chk_sel = 1'b0;
        sb.push_back(e);
        for (int n = -1; n < 16; n++) begin
            w = (n < 0) ? pc : regs[n];
            for (int k = 0; k < 4; k++) begin
                e.b = w[8*k +: 8];
                e.sel = (n < 0) ? 4'd0 : 4'(n);
                e.chk_sel = (n >= 0);
`ifdef DEBUG_DUMP_CHECKSUM_EN
                cs ^= e.b;
`endif
                sb.push_back(e);
            end
        end
`ifdef DEBUG_DUMP_CHECKSUM_EN
        e.b = cs;
        e.sel = 4'd15;
        e.chk_sel = 1'b1;
        sb.push_back(e);
`endif
    endtask

    task automatic start_frame(input logic [31:0] pc);
        fetchPC = pc;
        push_frame(pc);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        t0 = cyc;
        check("busy_at_start", {31'b0, busy}, 1);
        check("tx_at_start", {31'b0, uart_tx}, 0);
    endtask

    task automatic wait_done(input bit extra_start);
        int k;
        bit seen;
        k = 0;
        seen = 1'b0;
        while (!seen && k < FRAME_CYC + 200) begin
            @(negedge clk);
            k++;
            start = extra_start && (k == 1000);
            if (done)
                seen = 1'b1;
        end
        check("done_seen", {31'b0, seen}, 1);
        check("done_cycle", cyc - t0, FRAME_CYC);
        check("busy_at_done", {31'b0, busy}, 0);
        if (extra_start) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic idle_after(input int exp_done);
        repeat (60) @(negedge clk);
        check("busy_idle", {31'b0, busy}, 0);
        check("tx_idle", {31'b0, uart_tx}, 1);
        check("sb_empty", sb.size(), 0);
        check("done_count", done_cnt, exp_done);
    endtask

    // UART decoder: mid-bit sampling on the falling edge
    initial begin
        bit on;
        int cnt;
        int nb;
        logic [7:0] sh;
        exp_t e;
        on = 1'b0;
        cnt = 0;
        nb = 0;
        sh = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                on = 1'b0;
            end else if (!on) begin
                if (uart_tx === 1'b0) begin
                    on = 1'b1;
                    cnt = 0;
                    nb = 0;
                end
            end else begin
                cnt++;
                if (cnt == CPB * (nb + 1) + CPB / 2) begin
                    if (nb < 8) begin
                        sh = {uart_tx, sh[7:1]};
                    end else begin
                        check("stop_bit", {31'b0, uart_tx}, 1);
                        check("sb_has_entry",
                              {31'b0, sb.size() > 0}, 1);
                        if (sb.size() > 0) begin
                            e = sb.pop_front();
                            check($sformatf("byte%0d", rx_count),
                                  {24'b0, sh}, {24'b0, e.b});
                            if (e.chk_sel)
                                check("reg_select",
                                      {28'b0, debug_reg_select},
                                      {28'b0, e.sel});
                        end
                        on = 1'b0;
                        rx_count++;
                    end
                    nb++;
                end
            end
        end
    end

    initial begin
        int k;
        int rx0;
        for (int i = 0; i < 16; i++)
            regs[i] = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        repeat (100) begin
            @(negedge clk);
            check("rst_tx", {31'b0, uart_tx}, 1);
            check("rst_busy", {31'b0, busy}, 0);
            check("rst_sel", {28'b0, debug_reg_select}, 0);
        end
        check("rst_done", {31'b0, done}, 0);

        for (int i = 0; i < 16; i++)
            regs[i] = 32'h1111_1111 * i;
        start_frame(32'h0000_0010);
        wait_done(1'b1);
        idle_after(1);
        check("sel_holds", {28'b0, debug_reg_select}, 15);

        for (int i = 0; i < 16; i++)
            regs[i] = $urandom;
        rx0 = rx_count;
        start_frame(32'hDEAD_BEEF);
        k = 0;
        while (rx_count < rx0 + 20 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("byte20_reached", {31'b0, rx_count >= rx0 + 20}, 1);
        repeat (8) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_tx", {31'b0, uart_tx}, 1);
        check("mid_rst_busy", {31'b0, busy}, 0);
        check("mid_rst_sel", {28'b0, debug_reg_select}, 0);
        check("mid_rst_done", {31'b0, done}, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        repeat (200) @(negedge clk);
        check("no_done_after_rst", done_cnt, 1);
        check("busy_after_rst", {31'b0, busy}, 0);

        start_frame(32'h8000_1234);
        wait_done(1'b0);
        idle_after(2);

        for (int i = 0; i < 16; i++)
            regs[i] = '0;
        start_frame(32'h0102_0304);
        wait_done(1'b0);
        idle_after(3);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/debug_reg_dumper.md
# debug_reg_dumper

Host-side debug companion for the single-cycle computer top. On a start pulse, it does three things:
- snapshots `fetchPC`;
- walks `debug_reg_select` through R0–R15 and captures each `debug_reg_out` word;
- serialises the whole dump as one framed 8N1 UART byte stream.

It drives the select end of the computer's debug register port and consumes its data end, so a bench or board can read the complete architectural state through one TX pin.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per UART bit. Legal range is ≥2.
- `clk` in 1: system clock, shared with the computer.
- `reset` in 1: synchronous, active-high.
- `start` in 1: single-cycle request to begin a dump. Ignored while `busy`.
- `fetchPC` in 32: current PC from the computer.
- `debug_reg_out` in 32: register value for the current `debug_reg_select`. Combinational in the computer.
- `debug_reg_select` out 4: register index driven to the computer.
- `uart_tx` out 1: serial output, idle high.
- `busy` out 1: high from start acceptance until the frame completes.
- `done` out 1: one-cycle pulse when the final stop bit ends.

## Operation
- Frame layout, in order:
  - header byte 0xA5;
  - PC as 4 bytes;
  - R0..R15, 4 bytes each;
  - 69 bytes total.
- Words are sent little-endian: bits [7:0] first.
- Each byte is 8N1: start bit 0, data LSB first, stop bit 1.
- States:
  - IDLE: `start`=1 → capture `fetchPC` into the word buffer, load 0xA5, go to SEND.
  - SEND: transmit the current byte. When the stop bit ends:
    - next byte of the current word → stay in SEND;
    - word finished and registers remain → SELECT;
    - last byte of R15 → FINISH.
  - SELECT: drive `debug_reg_select` = next index. One cycle, then CAPTURE.
  - CAPTURE: latch `debug_reg_out` into the word buffer. One cycle, then SEND.
  - FINISH: pulse `done`, drop `busy`, return to IDLE.
- Register index counter is 4 bits and runs 0..15. Completion is detected by a separate last-register flag, not by wrap to 0.
- `debug_reg_select` holds its last value in IDLE. It returns to 0 only on reset.
- Each register value is sampled at its own CAPTURE cycle. Dump coherency requires the computer to be held (for example, its clock gated) by the system; this block does not stall it.

## Timing
- Reset values: `uart_tx`=1, `busy`=0, `done`=0, `debug_reg_select`=0, state IDLE.
- `start` is sampled at edge E. At E+1, `busy`=1 and `uart_tx`=0 (header start bit).
- Each bit lasts exactly `CLKS_PER_BIT` cycles, so one byte is 10·`CLKS_PER_BIT` cycles.
- Consecutive bytes within a word have no idle gap.
- Each register word is preceded by exactly 2 idle-high cycles (SELECT and CAPTURE).
- Frame length from start acceptance to the `done` pulse: 69·10·`CLKS_PER_BIT` + 32 cycles. `done` is high the cycle after the final stop bit's last cycle, and `busy` falls in that same cycle.
- `start` while `busy` is dropped, not queued. `start` in the same cycle as `done` is also ignored.
- `reset` mid-frame: the next edge restores all reset values and `uart_tx` goes high at once. The partial frame is abandoned and no `done` pulse is issued.
- `start` and `reset` asserted together: reset wins.

## Configuration
- `DEBUG_DUMP_CHECKSUM_EN` defined:
  - one extra byte is appended after R15: the XOR of all 68 PC and register bytes (header excluded);
  - frame is 70 bytes; length formula becomes 70·10·`CLKS_PER_BIT` + 32.
- Undefined: 69-byte frame, no checksum logic.

## Structure
- Shared package `debug_dump_pkg` holds:
  - `DUMP_HEADER` = 8'hA5;
  - `DUMP_NUM_REGS` = 16;
  - frame byte counts with and without checksum;
  - the state enum (IDLE, SEND, SELECT, CAPTURE, FINISH).
- One sub-module, `uart_tx_byte`:
  - inputs: `clk`, `reset`, `load`, 8-bit `data`;
  - outputs: `tx`, `ready`, `byte_done`;
  - owns the bit-period counter and bit index.
- The top FSM owns the word buffer, byte index (0..3), register index and checksum accumulator.

## Test plan
All scenarios use `CLKS_PER_BIT`=4.
- Reset then idle:
  - `uart_tx`=1, `busy`=0 and `debug_reg_select`=0 for 100 cycles.
- PC=0x0000_0010 and Rn=0x1111_1111·n, pulse `start`:
  - decoded bytes are A5 10 00 00 00, 00 00 00 00, 11 11 11 11, ... , FF FF FF FF;
  - `done` at cycle 2792 after acceptance.
- Each SELECT cycle:
  - `debug_reg_select` steps 0,1,...,15, one step per word.
  - Each captured word matches the model at its CAPTURE cycle.
- `start` pulsed mid-frame and again on the `done` cycle:
  - both are ignored; exactly one frame is emitted.
- `reset` asserted during byte 20:
  - `uart_tx`=1 and `busy`=0 on the next edge, with no `done`.
  - A fresh `start` yields a complete, correct frame.
- With `DEBUG_DUMP_CHECKSUM_EN`, all registers 0 and PC=0x0102_0304:
  - byte 70 is 0x04 (XOR of 04 03 02 01);
  - `done` at cycle 2832.
